// File: rtl/responder_arbiter.sv
// responder_arbiter: receiving end of the 5-bit contestant button bus.
// Synchronises and debounces each button, arms on a host start pulse,
// locks the first valid press, then runs the answer timer.
// Optional feature macro: RESPONDER_FOUL_DETECT_EN (early presses in IDLE
// become sticky fouls and are masked while ARMED).
module responder_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ANSWER_CYCLES   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn,
  input  logic        start,
  input  logic        clear,
  output logic [4:0]  winner,
  output logic [2:0]  winner_id,
  output logic        winner_valid,
  output logic        armed,
  output logic [15:0] time_left,
  output logic        time_up,
  output logic [4:0]  foul
);

`ifdef RESPONDER_FOUL_DETECT_EN
  localparam bit FOUL_EN = 1'b1;
`else
  localparam bit FOUL_EN = 1'b0;
`endif

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [4:0]      sync1, sync2;
  logic [4:0]      db, db_d;
  logic [CW-1:0]   cnt [5];
  logic [4:0]      press;
  logic [4:0]      eligible;
  logic [4:0]      pick;
  logic [2:0]      pick_id;
  logic [4:0]      winner_n;
  logic [2:0]      winner_id_n;
  logic            winner_valid_n;
  logic [15:0]     time_left_n;
  logic            time_up_n;
  logic [4:0]      foul_n;

  // Two-flop synchroniser for the asynchronous button lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Per-bit debouncer: the level flips on the differing sample that follows
  // DEBOUNCE_CYCLES already-counted differing samples; any agreement restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      db   <= '0;
      db_d <= '0;
      for (int unsigned k = 0; k < 5; k++) cnt[k] <= '0;
    end else begin
      db_d <= db;
      for (int unsigned k = 0; k < 5; k++) begin
        if (sync2[k] != db[k]) begin
          if (cnt[k] == CW'(DEBOUNCE_CYCLES)) begin
            db[k]  <= ~db[k];
            cnt[k] <= '0;
          end else begin
            cnt[k] <= cnt[k] + 1'b1;
          end
        end else begin
          cnt[k] <= '0;
        end
      end
    end
  end

  assign press    = db & ~db_d;
  assign eligible = press & ~foul;

  // Priority pick: the highest bus bit (lowest contestant number) wins.
  always_comb begin
    pick    = '0;
    pick_id = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (eligible[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
        pick_id = 3'(5 - i);
      end
    end
  end

  // Next-state and next-output logic; clear overrides everything else.
  always_comb begin
    state_n        = state;
    winner_n       = winner;
    winner_id_n    = winner_id;
    winner_valid_n = winner_valid;
    time_left_n    = time_left;
    time_up_n      = 1'b0;
    foul_n         = foul;
    case (state)
      IDLE: begin
        if (FOUL_EN) foul_n = foul | press;
        if (start) state_n = ARMED;
      end
      ARMED: begin
        if (|eligible) begin
          state_n        = LOCKED;
          winner_n       = pick;
          winner_id_n    = pick_id;
          winner_valid_n = 1'b1;
          time_left_n    = 16'(ANSWER_CYCLES);
        end
      end
      LOCKED: begin
        if (time_left == 16'd1) begin
          time_left_n = '0;
          time_up_n   = 1'b1;
          state_n     = DONE;
        end else begin
          time_left_n = time_left - 16'd1;
        end
      end
      DONE: ;
      default: state_n = IDLE;
    endcase
    if (clear) begin
      state_n        = IDLE;
      winner_n       = '0;
      winner_id_n    = '0;
      winner_valid_n = 1'b0;
      time_left_n    = '0;
      time_up_n      = 1'b0;
      foul_n         = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      winner       <= '0;
      winner_id    <= '0;
      winner_valid <= 1'b0;
      armed        <= 1'b0;
      time_left    <= '0;
      time_up      <= 1'b0;
      foul         <= '0;
    end else begin
      state        <= state_n;
      winner       <= winner_n;
      winner_id    <= winner_id_n;
      winner_valid <= winner_valid_n;
      armed        <= (state_n == ARMED);
      time_left    <= time_left_n;
      time_up      <= time_up_n;
      foul         <= foul_n;
    end
  end

endmodule

// File: tb/tb_responder_arbiter.sv
// Directed bench for responder_arbiter with DEBOUNCE_CYCLES=4, ANSWER_CYCLES=5.
// Expected foul behaviour follows RESPONDER_FOUL_DETECT_EN when defined.
module tb_responder_arbiter;

`ifdef RESPONDER_FOUL_DETECT_EN
  localparam bit FOUL_EN = 1'b1;
`else
  localparam bit FOUL_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  btn;
  logic        start;
  logic        clear;
  logic [4:0]  winner;
  logic [2:0]  winner_id;
  logic        winner_valid;
  logic        armed;
  logic [15:0] time_left;
  logic        time_up;
  logic [4:0]  foul;

  int n_cmp = 0;
  int n_bad = 0;

  responder_arbiter #(
    .DEBOUNCE_CYCLES(4),
    .ANSWER_CYCLES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .start(start),
    .clear(clear),
    .winner(winner),
    .winner_id(winner_id),
    .winner_valid(winner_valid),
    .armed(armed),
    .time_left(time_left),
    .time_up(time_up),
    .foul(foul)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  btn;
    logic        start;
    logic        clear;
    logic [4:0]  w;
    logic [2:0]  id;
    logic        v;
    logic        a;
    logic [15:0] tl;
    logic        tu;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic [4:0] b, input logic s, input logic c,
                              input logic [4:0] w, input logic [2:0] id,
                              input logic v, input logic a,
                              input logic [15:0] tl, input logic tu);
    vec_t r;
    r.btn = b; r.start = s; r.clear = c;
    r.w = w; r.id = id; r.v = v; r.a = a; r.tl = tl; r.tu = tu;
    return r;
  endfunction

  // Advance n rising edges, then sample 1ns after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [4:0] w, input logic [2:0] id,
                     input logic v, input logic a, input logic [15:0] tl,
                     input logic tu, input logic [4:0] f);
    logic [31:0] got, exp;
    got = {winner, winner_id, winner_valid, armed, time_left, time_up, foul};
    exp = {w, id, v, a, tl, tu, f};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got w=%b id=%0d v=%b a=%b tl=%0d tu=%b f=%b ; want w=%b id=%0d v=%b a=%b tl=%0d tu=%b f=%b",
               name, winner, winner_id, winner_valid, armed, time_left, time_up, foul,
               w, id, v, a, tl, tu, f);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn = '0; start = 1'b0; clear = 1'b0;

    vecs[0] = mk(5'b00000, 1, 0, 5'b00000, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 7; i++)
      vecs[i] = mk(5'b00100, 0, 0, 5'b00000, 0, 0, 1, 0, 0);
    vecs[8] = mk(5'b00100, 0, 0, 5'b00100, 3, 1, 0, 5, 0);
    for (int i = 9; i <= 12; i++)
      vecs[i] = mk(5'b00100, 0, 0, 5'b00100, 3, 1, 0, 16'(13 - i), 0);
    vecs[13] = mk(5'b00100, 0, 0, 5'b00100, 3, 1, 0, 0, 1);
    vecs[14] = mk(5'b00100, 0, 0, 5'b00100, 3, 1, 0, 0, 0);
    vecs[15] = mk(5'b00100, 1, 0, 5'b00100, 3, 1, 0, 0, 0);
    vecs[16] = mk(5'b00000, 0, 1, 5'b00000, 0, 0, 0, 0, 0);

    cyc(3);
    chk("reset", '0, 0, 0, 0, 0, 0, '0);
    rst = 1'b0;
    cyc(1);

    // Table: arm, single press latency, full timer run, DONE ignores start, clear.
    for (int i = 0; i < 17; i++) begin
      btn = vecs[i].btn; start = vecs[i].start; clear = vecs[i].clear;
      cyc(1);
      chk($sformatf("vec%0d", i), vecs[i].w, vecs[i].id, vecs[i].v, vecs[i].a,
          vecs[i].tl, vecs[i].tu, '0);
    end
    start = 1'b0; clear = 1'b0;
    cyc(10);

    // Simultaneous rising edges: contestant 2 beats contestant 5.
    pulse_start();
    btn = 5'b01001;
    cyc(7);
    chk("simul_pre", '0, 0, 0, 1, 0, 0, '0);
    cyc(1);
    chk("simul_lock", 5'b01000, 2, 1, 0, 5, 0, '0);
    btn = 5'b11001;
    cyc(8);
    chk("late_press", 5'b01000, 2, 1, 0, 0, 0, '0);
    btn = '0;
    pulse_clear();
    chk("simul_clear", '0, 0, 0, 0, 0, 0, '0);
    cyc(10);

    // Three-cycle glitch on bit 0 must not lock.
    pulse_start();
    btn = 5'b00001;
    cyc(3);
    btn = '0;
    cyc(10);
    chk("glitch", '0, 0, 0, 1, 0, 0, '0);
    pulse_clear();
    chk("glitch_clear", '0, 0, 0, 0, 0, 0, '0);
    cyc(2);

    // Button held across start; only a re-press can win.
    btn = 5'b00010;
    cyc(10);
    chk("held_idle", '0, 0, 0, 0, 0, 0, FOUL_EN ? 5'b00010 : 5'b00000);
    pulse_start();
    chk("held_arm", '0, 0, 0, 1, 0, 0, FOUL_EN ? 5'b00010 : 5'b00000);
    cyc(10);
    chk("held_nolock", '0, 0, 0, 1, 0, 0, FOUL_EN ? 5'b00010 : 5'b00000);
    btn = '0;
    cyc(10);
    chk("released", '0, 0, 0, 1, 0, 0, FOUL_EN ? 5'b00010 : 5'b00000);
    btn = 5'b00010;
    cyc(8);
    if (FOUL_EN) chk("repress", '0, 0, 0, 1, 0, 0, 5'b00010);
    else         chk("repress", 5'b00010, 4, 1, 0, 5, 0, '0);
    btn = '0;
    clear = 1'b1; start = 1'b1;
    cyc(1);
    clear = 1'b0; start = 1'b0;
    chk("clear_start", '0, 0, 0, 0, 0, 0, '0);
    cyc(1);
    chk("clear_start_idle", '0, 0, 0, 0, 0, 0, '0);
    cyc(10);

    // Early press in IDLE: foul when enabled, otherwise no effect.
    btn = 5'b10000;
    cyc(8);
    chk("idle_press", '0, 0, 0, 0, 0, 0, FOUL_EN ? 5'b10000 : 5'b00000);
    btn = '0;
    cyc(10);
    pulse_start();
    btn = 5'b10000;
    cyc(8);
    if (FOUL_EN) chk("c1_press", '0, 0, 0, 1, 0, 0, 5'b10000);
    else         chk("c1_press", 5'b10000, 1, 1, 0, 5, 0, '0);
    btn = '0;
    cyc(10);
    btn = 5'b00010;
    cyc(8);
    if (FOUL_EN) chk("c4_press", 5'b00010, 4, 1, 0, 5, 0, 5'b10000);
    else         chk("c4_press", 5'b10000, 1, 1, 0, 0, 0, '0);
    btn = '0;
    pulse_clear();
    chk("foul_clear", '0, 0, 0, 0, 0, 0, '0);
    cyc(10);

    // Reset in the middle of the answer window.
    pulse_start();
    btn = 5'b00100;
    cyc(8);
    chk("rst_lock", 5'b00100, 3, 1, 0, 5, 0, '0);
    cyc(2);
    chk("rst_count", 5'b00100, 3, 1, 0, 3, 0, '0);
    rst = 1'b1; btn = '0;
    cyc(1);
    chk("mid_rst", '0, 0, 0, 0, 0, 0, '0);
    rst = 1'b0;
    cyc(10);
    chk("post_rst", '0, 0, 0, 0, 0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/responder_arbiter.md
Name: responder_arbiter

Overview:
- Receiving end of the bundled 5-bit contestant button bus (bit 4 = contestant 1 … bit 0 = contestant 5).
- Synchronises and debounces each line, then arbitrates the first valid press after the host arms the round.
- Locks out all other contestants and runs an answer timer.
- Feeds the display/buzzer logic with a one-hot winner, a winner number and a timeout pulse.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable samples needed to change a debounced level (≥1)
ANSWER_CYCLES, 1000, answer window length in clk cycles after lock (≥2, ≤65535)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
btn  input  5  raw bundled button bus, bit 4 = contestant 1, asynchronous, active-high
start  input  1  host arm pulse, one cycle
clear  input  1  host clear pulse, one cycle; ends the round
winner  output  5  one-hot winner in bus order, 0 = none
winner_id  output  3  winner number 1..5, 0 = none
winner_valid  output  1  high while a winner is latched (LOCKED or DONE)
armed  output  1  high in ARMED
time_left  output  16  remaining answer cycles, 0 outside LOCKED
time_up  output  1  one-cycle pulse when the answer window expires
foul  output  5  sticky early-press flags, bus order

Behaviour:
- Reset: all outputs 0; state IDLE; sync flops, debounced levels and counters 0.
- Input path, per bit:
  - 2-flop synchroniser, then debouncer.
  - Debounced level db[k] toggles when the synchronised bit has differed from db[k] for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreeing sample resets that bit's counter.
  - Press event = db[k] rising, one cycle.
- Latency: btn[k] first sampled high at edge N and held → db[k] rises at edge N+DEBOUNCE_CYCLES+2 → winner outputs valid after edge N+DEBOUNCE_CYCLES+3.
- State IDLE:
  - armed=0.
  - start → ARMED.
  - Press events are ignored, except as defined under Optional Feature.
- State ARMED:
  - armed=1.
  - On the first cycle with any press event (from non-fouled contestants), go to LOCKED next edge.
  - Latch winner/winner_id; winner_valid=1; load time_left=ANSWER_CYCLES.
  - Simultaneous press events in one cycle: the lowest contestant number (highest bus bit) wins.
  - A button already held when start arrives has no rising edge, so it does not win; it must be released and re-pressed.
  - start while ARMED: ignored.
- State LOCKED:
  - time_left decrements by 1 each cycle.
  - On the cycle time_left==1: next edge time_left=0, time_up=1 for exactly that one cycle, state DONE.
  - All press events and start are ignored.
- State DONE:
  - winner/winner_id/winner_valid held.
  - start and presses ignored.
  - Only clear leaves this state.
- clear (any state):
  - Next edge: state IDLE; winner, winner_id, winner_valid, time_left, time_up, foul all 0.
  - Debouncer state is kept.
  - clear and start in the same cycle: clear wins; state IDLE.
- rst mid-round: identical to the reset values above, including debouncers.
- Outputs are registered; no combinational path from btn/start/clear to any output.
- State encoding: IDLE=0, ARMED=1, LOCKED=2, DONE=3 (internal, 2 bits).

Optional Feature:
- Macro: RESPONDER_FOUL_DETECT_EN.
- Defined:
  - A press event in IDLE sets foul[k] (sticky until clear/rst).
  - Fouled contestants' press events are masked in ARMED.
  - If every unfouled bit is masked, the round stays ARMED until clear.
- Not defined: foul tied to 0; IDLE presses have no effect.

Test Plan:
- DEBOUNCE_CYCLES=4, rst, start, btn=5'b00100 held → winner=00100, winner_id=3, winner_valid=1 exactly 7 edges after first high sample; time_left=ANSWER_CYCLES.
- Armed, btn=5'b01001 rising in same cycle → winner=01000, winner_id=2; later btn=5'b10000 press → no change.
- btn bit 0 glitches high for 3 cycles (DEBOUNCE_CYCLES=4) while ARMED → no lock; armed stays 1.
- ANSWER_CYCLES=5 after lock → time_left 5,4,3,2,1,0; time_up high one cycle at 0; state DONE; winner held until clear, then all outputs 0.
- btn held across start, then released and re-pressed → lock only on the re-press; clear asserted with start in the same cycle → stays IDLE, armed=0.
- With RESPONDER_FOUL_DETECT_EN: contestant 1 presses in IDLE → foul=10000; start, contestant 1 presses again → ignored; contestant 4 presses → winner_id=4; clear → foul=0.
